// File: rtl/psm_pkg.sv
// Shared types, default widths and arithmetic helpers for the PSM phase-shift ramp.
package psm_pkg;

    localparam int unsigned BITS_DATA_DEF = 16;
    localparam int unsigned STEP_W_DEF    = 8;
    localparam int unsigned ACC_W         = BITS_DATA_DEF + 2;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        HOLD,
        STOP,
        FAULT
    } psm_state_t;

    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic acc_t f_clamp(input acc_t v, input acc_t lim);
        if (v > lim)
            return lim;
        else if (v < -lim)
            return -lim;
        return v;
    endfunction

    function automatic acc_t f_abs(input acc_t v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/psm_ramp_axis.sv
// One shift axis: clamps the target to +/-F and slews the applied value by at most one step per tick.
module psm_ramp_axis
    import psm_pkg::*;
#(
    parameter int unsigned BITS_DATA = BITS_DATA_DEF,
    parameter int unsigned STEP_W    = STEP_W_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_tick,
    input  logic                        i_zero_req,
    input  logic                        i_stop_req,
    input  logic [BITS_DATA-1:0]        i_freq,
    input  logic [STEP_W-1:0]           i_step,
    input  logic signed [BITS_DATA:0]   i_target,
    output acc_t                        o_cur_next,
    output logic                        o_at_target,
    output logic                        o_next_at_target
);

    acc_t r_cur;
    acc_t w_lim;
    acc_t w_eff;
    acc_t w_diff;
    acc_t w_mag;
    acc_t w_step;
    acc_t w_ramp;
    acc_t w_next;

    always_comb begin
        w_lim  = acc_t'(i_freq);
        w_eff  = i_stop_req ? '0 : f_clamp(acc_t'(i_target), w_lim);
        w_diff = w_eff - r_cur;
        w_mag  = f_abs(w_diff);
        w_step = acc_t'(i_step);
        if (w_step == '0 || w_mag <= w_step)
            w_ramp = w_eff;
        else if (w_diff < 0)
            w_ramp = r_cur - w_step;
        else
            w_ramp = r_cur + w_step;

        if (i_zero_req)
            w_next = '0;
        else if (i_tick)
            w_next = w_ramp;
        else
            w_next = r_cur;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cur <= '0;
        else
            r_cur <= w_next;
    end

    assign o_cur_next       = w_next;
    assign o_at_target      = (r_cur == w_eff);
    assign o_next_at_target = (w_ramp == w_eff);

endmodule

// File: rtl/psm_shift_ramp.sv
// Slew-limited SPS/DPS phase-shift command stage: period counter, run/stop/fault FSM,
// target handshake and tick-aligned magnitude/sign output registers.
module psm_shift_ramp
    import psm_pkg::*;
#(
    parameter int unsigned BITS_DATA = BITS_DATA_DEF,
    parameter int unsigned STEP_W    = STEP_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [BITS_DATA-1:0]  iFREQUENCY,
    input  logic [STEP_W-1:0]     iSTEP,
    input  logic                  iEnable,
    input  logic                  iFault,
    input  logic                  iTarget_valid,
    output logic                  oTarget_ready,
    input  logic [BITS_DATA:0]    iSPS_target,
    input  logic [BITS_DATA:0]    iDPS_target,
    input  logic                  iN_target,
    output logic [BITS_DATA-1:0]  oSPS_value,
    output logic [BITS_DATA-1:0]  oDPS_value,
    output logic                  oSPS_sign,
    output logic                  oDPS_sign,
    output logic                  oN,
    output logic                  oPeriod_tick,
    output logic                  oBusy,
    output logic                  oAt_target
);

    psm_state_t r_state;
    psm_state_t w_state_nxt;

    logic [BITS_DATA-1:0]     r_cnt;
    logic                     w_tick;
    logic                     r_ready_en;
    logic                     w_capture;
    logic signed [BITS_DATA:0] r_sps_tgt;
    logic signed [BITS_DATA:0] r_dps_tgt;
    logic                     r_n_tgt;
    logic                     w_zero_req;
    logic                     w_stop_req;
    acc_t                     w_sps_next;
    acc_t                     w_dps_next;
    logic                     w_sps_at, w_dps_at;
    logic                     w_sps_next_at, w_dps_next_at;
    logic                     w_busy_nxt;
    logic                     w_at_nxt;

    logic [BITS_DATA-1:0]     r_sps_value;
    logic [BITS_DATA-1:0]     r_dps_value;
    logic                     r_sps_sign;
    logic                     r_dps_sign;
    logic                     r_n;
    logic                     r_period_tick;
    logic                     r_busy;
    logic                     r_at_target;

    // >= keeps the period bounded if F is lowered below the running count
    assign w_tick = (r_cnt >= iFREQUENCY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Holds ready low until the first clock after reset release
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_ready_en <= 1'b0;
        else
            r_ready_en <= 1'b1;
    end

    assign oTarget_ready = r_ready_en && (r_state != FAULT);
    assign w_capture     = iTarget_valid && oTarget_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sps_tgt <= '0;
            r_dps_tgt <= '0;
            r_n_tgt   <= 1'b0;
        end else if (w_capture) begin
            r_sps_tgt <= iSPS_target;
            r_dps_tgt <= iDPS_target;
            r_n_tgt   <= iN_target;
        end
    end

    assign w_zero_req = iFault || (r_state == IDLE) || (r_state == FAULT);
    assign w_stop_req = (r_state == STOP) ||
                        (!iEnable && ((r_state == RAMP) || (r_state == HOLD)));

    psm_ramp_axis #(.BITS_DATA(BITS_DATA), .STEP_W(STEP_W)) u_sps (
        .i_clk            (CLK),
        .i_rst            (RST),
        .i_tick           (w_tick),
        .i_zero_req       (w_zero_req),
        .i_stop_req       (w_stop_req),
        .i_freq           (iFREQUENCY),
        .i_step           (iSTEP),
        .i_target         (r_sps_tgt),
        .o_cur_next       (w_sps_next),
        .o_at_target      (w_sps_at),
        .o_next_at_target (w_sps_next_at)
    );

    psm_ramp_axis #(.BITS_DATA(BITS_DATA), .STEP_W(STEP_W)) u_dps (
        .i_clk            (CLK),
        .i_rst            (RST),
        .i_tick           (w_tick),
        .i_zero_req       (w_zero_req),
        .i_stop_req       (w_stop_req),
        .i_freq           (iFREQUENCY),
        .i_step           (iSTEP),
        .i_target         (r_dps_tgt),
        .o_cur_next       (w_dps_next),
        .o_at_target      (w_dps_at),
        .o_next_at_target (w_dps_next_at)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (iFault) begin
            w_state_nxt = FAULT;
        end else begin
            unique case (r_state)
                IDLE:  if (iEnable) w_state_nxt = RAMP;
                RAMP: begin
                    if (!iEnable)
                        w_state_nxt = STOP;
                    else if (w_tick && w_sps_next_at && w_dps_next_at)
                        w_state_nxt = HOLD;
                end
                HOLD: begin
                    if (!iEnable)
                        w_state_nxt = STOP;
                    else if (!(w_sps_at && w_dps_at))
                        w_state_nxt = RAMP;
                end
                STOP: begin
                    if (iEnable)
                        w_state_nxt = RAMP;
                    else if (w_tick && w_sps_next_at && w_dps_next_at)
                        w_state_nxt = IDLE;
                end
                FAULT: if (!iEnable) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == RAMP) || (w_state_nxt == STOP);
        w_at_nxt   = (w_state_nxt == HOLD);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sps_value   <= '0;
            r_dps_value   <= '0;
            r_sps_sign    <= 1'b1;
            r_dps_sign    <= 1'b1;
            r_n           <= 1'b0;
            r_period_tick <= 1'b0;
            r_busy        <= 1'b0;
            r_at_target   <= 1'b0;
        end else begin
            r_period_tick <= w_tick;
            r_busy        <= w_busy_nxt;
            r_at_target   <= w_at_nxt;
            if (iFault || (r_state == FAULT)) begin
                r_sps_value <= '0;
                r_dps_value <= '0;
                r_sps_sign  <= 1'b1;
                r_dps_sign  <= 1'b1;
                r_n         <= 1'b0;
            end else if (w_tick) begin
                r_sps_value <= BITS_DATA'(f_abs(w_sps_next));
                r_dps_value <= BITS_DATA'(f_abs(w_dps_next));
                r_sps_sign  <= (w_sps_next >= 0);
                r_dps_sign  <= (w_dps_next >= 0);
                r_n         <= r_n_tgt;
            end
        end
    end

    assign oSPS_value   = r_sps_value;
    assign oDPS_value   = r_dps_value;
    assign oSPS_sign    = r_sps_sign;
    assign oDPS_sign    = r_dps_sign;
    assign oN           = r_n;
    assign oPeriod_tick = r_period_tick;
    assign oBusy        = r_busy;
    assign oAt_target   = r_at_target;

endmodule
